// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter slice.
//   arb_state_t                : arbiter FSM encoding (IDLE / SEND / WAIT)
//   UART_ARB_TIMEOUT_CLKS_DEF  : default stall limit in clocks, only used when
//                                UART_ARB_TIMEOUT_EN is defined
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    localparam int UART_ARB_TIMEOUT_CLKS_DEF = 1024;

endpackage

// File: rtl/uart_rr_pick.sv
// -----------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin picker: returns the first set request bit found
// searching upward from ptr_i+1, wrapping past NUM_REQ-1 back to 0.
// Ports:
//   req_i      in  NUM_REQ  request vector
//   ptr_i      in  IW       index of the most recent owner
//   win_o      out NUM_REQ  one-hot winner (all-zero when no request)
//   win_idx_o  out IW       index of the winner (0 when no request)
// -----------------------------------------------------------------------------
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] win_o,
    output logic [IW-1:0]      win_idx_o
);

    always_comb begin : p_pick
        logic [IW:0]   w_sum;
        logic [IW-1:0] w_pos;
        w_sum     = '0;
        w_pos     = '0;
        win_o     = '0;
        win_idx_o = '0;
        // Scan from the farthest candidate toward the nearest so the nearest
        // set bit after ptr_i is the last one written and therefore wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_sum = {1'b0, ptr_i} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IW+1)'(NUM_REQ);
            end
            w_pos = w_sum[IW-1:0];
            if (req_i[w_pos]) begin
                win_o        = '0;
                win_o[w_pos] = 1'b1;
                win_idx_o    = w_pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
// Packet-granular round-robin arbiter sharing one UART TX serializer between
// NUM_REQ byte-stream requesters. An owner keeps the transmitter from its first
// byte until its 'last' byte has been reported done by the serializer.
// Optional feature macro: UART_ARB_TIMEOUT_EN -- revokes the grant of an owner
// that stalls (valid low in SEND) for TIMEOUT_CLKS clocks.
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   req_valid_i/req_last_i   per-requester byte valid / end-of-packet flag
//   req_data_i               byte of requester i at [8i+7:8i]
//   req_ready_o              byte accepted when valid & ready
//   grant_o                  one-hot owner, zero when free
//   tx_start_o / tx_d_o      start pulse and byte to the serializer
//   tx_busy_i / tx_done_i    serializer shifting / byte-finished pulse
//   timeout_o                pulse when a grant is revoked by timeout
// -----------------------------------------------------------------------------
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT_CLKS = UART_ARB_TIMEOUT_CLKS_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 tx_start_o,
    output logic [7:0]           tx_d_o,
    input  logic                 tx_busy_i,
    input  logic                 tx_done_i,
    output logic                 timeout_o
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_t         r_state, w_state_next;
    logic [NUM_REQ-1:0] r_grant, w_grant_next;
    logic [IW-1:0]      r_gidx, w_gidx_next;
    logic [IW-1:0]      r_ptr, w_ptr_next;
    logic [7:0]         r_tx_d, w_tx_d_next;
    logic               r_tx_start, w_tx_start_next;
    logic               r_last, w_last_next;

    logic [7:0]         w_byte [NUM_REQ];
    logic [NUM_REQ-1:0] w_win;
    logic [IW-1:0]      w_win_idx;
    logic               w_sel_valid;
    logic               w_hs;
    logic               w_to_fire;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_byte[gi] = req_data_i[8*gi +: 8];
        end
    endgenerate

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req_i     (req_valid_i),
        .ptr_i     (r_ptr),
        .win_o     (w_win),
        .win_idx_o (w_win_idx)
    );

    assign w_sel_valid = req_valid_i[r_gidx];
    assign w_hs        = (r_state == ST_SEND) && w_sel_valid && !tx_busy_i;
    assign req_ready_o = ((r_state == ST_SEND) && !tx_busy_i) ? r_grant : '0;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    assign w_to_fire = (r_state == ST_SEND) && !w_sel_valid &&
                       (r_cnt == CW'(TIMEOUT_CLKS - 1));

    // Stall counter: only advances while the owner withholds data in SEND.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_fire;
            if ((r_state != ST_SEND) || w_hs || w_to_fire) begin
                r_cnt <= '0;
            end else if (!w_sel_valid) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_to_fire = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        w_state_next    = r_state;
        w_grant_next    = r_grant;
        w_gidx_next     = r_gidx;
        w_ptr_next      = r_ptr;
        w_tx_d_next     = r_tx_d;
        w_last_next     = r_last;
        w_tx_start_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req_valid_i) begin
                    w_grant_next = w_win;
                    w_gidx_next  = w_win_idx;
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_to_fire) begin
                    // Stalled owner goes to the back of the rotation.
                    w_ptr_next   = r_gidx;
                    w_grant_next = '0;
                    w_state_next = ST_IDLE;
                end else if (w_hs) begin
                    w_tx_d_next     = w_byte[r_gidx];
                    w_last_next     = req_last_i[r_gidx];
                    w_tx_start_next = 1'b1;
                    w_state_next    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tx_done_i) begin
                    if (r_last) begin
                        w_ptr_next   = r_gidx;
                        w_grant_next = '0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_SEND;
                    end
                end
            end
            default: begin
                w_grant_next = '0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_ptr      <= IW'(NUM_REQ - 1);
            r_tx_d     <= 8'h00;
            r_tx_start <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_gidx     <= w_gidx_next;
            r_ptr      <= w_ptr_next;
            r_tx_d     <= w_tx_d_next;
            r_tx_start <= w_tx_start_next;
            r_last     <= w_last_next;
        end
    end

    assign grant_o    = r_grant;
    assign tx_start_o = r_tx_start;
    assign tx_d_o     = r_tx_d;

endmodule
